// File: rtl/spi_byte_sequencer_if.sv
// Byte-stream and SPI-driver handshake bundle for spi_byte_sequencer.
// master = producer/consumer/driver environment, slave = the sequencer.
interface spi_byte_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] drv_data_in;
  logic       drv_start;
  logic       drv_en;
  logic [7:0] drv_data_out;
  logic       busy;
  logic [4:0] tx_level;
  logic       err;

  modport master (
    output tx_data, tx_valid, rx_ready, drv_en, drv_data_out,
    input  tx_ready, rx_data, rx_valid, drv_data_in, drv_start, busy, tx_level, err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, drv_en, drv_data_out,
    output tx_ready, rx_data, rx_valid, drv_data_in, drv_start, busy, tx_level, err
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Feeds bytes from a TX FIFO to a single-byte SPI driver and collects the replies.
// Define SPI_SEQ_RX_FIFO_EN to build the RX FIFO; otherwise received bytes are discarded.
module spi_byte_sequencer #(
  parameter int DEPTH      = 8,
  parameter int EN_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_byte_sequencer_if.slave  bus
);
  localparam int              AW     = $clog2(DEPTH);
  localparam int              TW     = (EN_TIMEOUT > 1) ? $clog2(EN_TIMEOUT) : 1;
  localparam logic [4:0]      FULL   = 5'(DEPTH);
  localparam logic [TW-1:0]   T_LAST = TW'(EN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_EN, WAIT_DONE, CAPTURE} state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr;
  logic [AW-1:0] r_tx_rptr;
  logic [4:0]    r_tx_count;
  logic [7:0]    r_drv_data;
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_launch_ok;
  logic          w_rx_push;
  logic          w_timeout;
  logic          w_drv_start;

  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_rx_push    = 1'b0;
    w_timeout    = 1'b0;
    w_drv_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_tx_count != 5'd0) && w_launch_ok) begin
          w_tx_pop     = 1'b1;
          w_state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        w_drv_start  = 1'b1;
        w_state_next = WAIT_EN;
      end
      WAIT_EN: begin
        if (bus.drv_en) begin
          w_state_next = WAIT_DONE;
        end else if (r_tcnt == T_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.drv_en) w_state_next = CAPTURE;
      end
      CAPTURE: begin
        w_rx_push    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // A full FIFO still accepts a push on the cycle the sequencer pops it.
  assign w_tx_push = bus.tx_valid && ((r_tx_count != FULL) || w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= 5'd0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 5'd1;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv_data <= 8'h00;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_tx_pop) r_drv_data <= r_tx_mem[r_tx_rptr];
      if (r_state == LAUNCH)                   r_tcnt <= '0;
      else if (r_state == WAIT_EN && !bus.drv_en) r_tcnt <= r_tcnt + TW'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

`ifdef SPI_SEQ_RX_FIFO_EN
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr;
  logic [AW-1:0] r_rx_rptr;
  logic [4:0]    r_rx_count;
  logic          w_rx_pop;

  // Launches only happen from IDLE, where nothing is in flight, so room for one byte suffices.
  assign w_launch_ok = (r_rx_count != FULL);
  assign w_rx_pop    = bus.rx_ready && (r_rx_count != 5'd0);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.drv_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= 5'd0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 5'd1;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 5'd1;
    end
  end

  assign bus.rx_valid = (r_rx_count != 5'd0);
  assign bus.rx_data  = r_rx_mem[r_rx_rptr];
`else
  logic w_unused;

  assign w_launch_ok  = 1'b1;
  assign bus.rx_valid = 1'b0;
  assign bus.rx_data  = 8'h00;
  assign w_unused     = &{1'b0, bus.rx_ready, bus.drv_data_out, w_rx_push};
`endif

  assign bus.tx_ready    = (r_tx_count != FULL);
  assign bus.tx_level    = r_tx_count;
  assign bus.busy        = (r_state != IDLE);
  assign bus.drv_start   = w_drv_start;
  assign bus.drv_data_in = r_drv_data;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench for spi_byte_sequencer: stimulus queues expected launch/RX bytes,
// monitors pop and compare them when drv_start or an RX handshake is seen.
module tb_spi_byte_sequencer;
  logic clk = 1'b0;
  logic rst;

  spi_byte_sequencer_if ifc();

  spi_byte_sequencer #(.DEPTH(8), .EN_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int         nCompared = 0;
  int         nMismatched = 0;
  int         cycle = 0;
  int         startCount = 0;
  int         lastStartCycle = 0;
  bit         respond = 1'b0;
  logic [7:0] txExp[$];
  logic [7:0] rxExp[$];
  logic [7:0] respQ[$];

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
  endtask

  task automatic sampleEdge;
    @(negedge clk);
    #1;
  endtask

  task automatic toDrive;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit withResp, input logic [7:0] resp, input bit expRx);
    int budget;
    budget = 100;
    while (ifc.tx_ready !== 1'b1 && budget > 0) begin
      toDrive();
      budget--;
    end
    if (budget == 0) begin
      failTimeout("tx_ready_wait");
      return;
    end
    ifc.tx_data  = d;
    ifc.tx_valid = 1'b1;
    txExp.push_back(d);
    if (withResp) respQ.push_back(resp);
`ifdef SPI_SEQ_RX_FIFO_EN
    if (expRx) rxExp.push_back(resp);
`else
    if (expRx && !withResp) $display("[TB] note: RX expectation ignored without RX FIFO");
`endif
    toDrive();
    ifc.tx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      sampleEdge();
      n++;
    end while (!(ifc.busy === 1'b0 && ifc.tx_level === 5'd0) && n < budget);
    if (!(ifc.busy === 1'b0 && ifc.tx_level === 5'd0)) failTimeout(name);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},        ifc.busy,        0);
    checkOutput({tag, "_drv_start"},   ifc.drv_start,   0);
    checkOutput({tag, "_drv_data_in"}, ifc.drv_data_in, 0);
    checkOutput({tag, "_err"},         ifc.err,         0);
    checkOutput({tag, "_tx_level"},    ifc.tx_level,    0);
    checkOutput({tag, "_tx_ready"},    ifc.tx_ready,    1);
    checkOutput({tag, "_rx_valid"},    ifc.rx_valid,    0);
  endtask

  // Monitor: every drv_start and every RX pop is matched against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (!rst && ifc.drv_start === 1'b1) begin
      startCount++;
      lastStartCycle = cycle;
      if (txExp.size() == 0) failTimeout("drv_start_unexpected");
      else checkOutput("drv_data_in", ifc.drv_data_in, txExp.pop_front());
    end
    if (!rst && ifc.rx_valid === 1'b1 && ifc.rx_ready === 1'b1) begin
      if (rxExp.size() == 0) failTimeout("rx_unexpected");
      else checkOutput("rx_data", ifc.rx_data, rxExp.pop_front());
    end
  end

  // SPI driver model: drv_en high on cycles 2..20 after drv_start, reply byte from respQ.
  initial begin
    ifc.drv_en       = 1'b0;
    ifc.drv_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && ifc.drv_start === 1'b1 && respond) begin
        ifc.drv_data_out = (respQ.size() != 0) ? respQ.pop_front() : 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 ifc.drv_en = 1'b1;
        repeat (19) @(posedge clk);
        #1 ifc.drv_en = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst          = 1'b1;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    ifc.rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    sampleEdge();
    checkResetValues("reset");
    toDrive();
    rst = 1'b0;
    toDrive();

    // Single transfer with reply 0x3C.
    base    = startCount;
    respond = 1'b1;
    applyStimulus(8'hA5, 1'b1, 8'h3C, 1'b1);
    waitIdle("single_idle", 60);
    checkOutput("single_starts", startCount - base, 1);
    checkOutput("single_drv_hold", ifc.drv_data_in, 8'hA5);
    checkOutput("single_err", ifc.err, 0);
`ifdef SPI_SEQ_RX_FIFO_EN
    checkOutput("single_rx_valid", ifc.rx_valid, 1);
    checkOutput("single_rx_data", ifc.rx_data, 8'h3C);
`else
    checkOutput("single_rx_valid", ifc.rx_valid, 0);
    checkOutput("single_rx_data", ifc.rx_data, 8'h00);
`endif
    toDrive();
    ifc.rx_ready = 1'b1;
    toDrive();
    checkOutput("single_rx_drained", ifc.rx_valid, 0);

    // Fill TX to 8 behind a long transfer, then let every launch time out.
    base = startCount;
    applyStimulus(8'h50, 1'b1, 8'h05, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, 8'h00, 1'b0);
    respond = 1'b0;
    sampleEdge();
    checkOutput("full_tx_level", ifc.tx_level, 8);
    checkOutput("full_tx_ready", ifc.tx_ready, 0);
    checkOutput("full_busy", ifc.busy, 1);
    checkOutput("full_err_before", ifc.err, 0);
    n = 0;
    while (ifc.err !== 1'b1 && n < 60) begin
      sampleEdge();
      n++;
    end
    if (ifc.err !== 1'b1) failTimeout("timeout_err_wait");
    else begin
      checkOutput("timeout_latency", cycle - lastStartCycle, 5);
      checkOutput("timeout_starts", startCount - base, 2);
    end
    waitIdle("timeout_drain", 200);
    checkOutput("timeout_all_starts", startCount - base, 9);
    checkOutput("timeout_err_sticky", ifc.err, 1);
    checkOutput("timeout_last_byte", ifc.drv_data_in, 8'h08);

    // Full FIFO in IDLE: simultaneous push of 0x11 and launch pop.
    toDrive();
    base    = startCount;
    respond = 1'b1;
    applyStimulus(8'h60, 1'b1, 8'h06, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h21 + i), 1'b1, 8'(8'hA1 + i), 1'b1);
    sampleEdge();
    checkOutput("pp_full_level", ifc.tx_level, 8);
    checkOutput("pp_full_ready", ifc.tx_ready, 0);
    n = 0;
    while (ifc.busy !== 1'b0 && n < 60) begin
      sampleEdge();
      n++;
    end
    if (ifc.busy !== 1'b0) failTimeout("pp_idle_wait");
    else begin
      ifc.tx_data  = 8'h11;
      ifc.tx_valid = 1'b1;
      txExp.push_back(8'h11);
      respQ.push_back(8'hB1);
`ifdef SPI_SEQ_RX_FIFO_EN
      rxExp.push_back(8'hB1);
`endif
      toDrive();
      ifc.tx_valid = 1'b0;
      sampleEdge();
      checkOutput("pp_level_kept", ifc.tx_level, 8);
      checkOutput("pp_busy", ifc.busy, 1);
    end
    waitIdle("pp_drain", 400);
    checkOutput("pp_starts", startCount - base, 10);
    checkOutput("pp_last_byte", ifc.drv_data_in, 8'h11);

    // RX back-pressure: rx_ready held low with 9 bytes queued.
    repeat (3) toDrive();
    ifc.rx_ready = 1'b0;
    base = startCount;
    for (int i = 0; i < 9; i++) applyStimulus(8'(8'h31 + i), 1'b1, 8'(8'hC1 + i), 1'b1);
`ifdef SPI_SEQ_RX_FIFO_EN
    n = 0;
    while (startCount - base < 8 && n < 400) begin
      sampleEdge();
      n++;
    end
    if (startCount - base < 8) failTimeout("rxfull_8_wait");
    n = 0;
    while (ifc.busy !== 1'b0 && n < 60) begin
      sampleEdge();
      n++;
    end
    repeat (40) sampleEdge();
    checkOutput("rxfull_stall_starts", startCount - base, 8);
    checkOutput("rxfull_tx_level", ifc.tx_level, 1);
    checkOutput("rxfull_rx_valid", ifc.rx_valid, 1);
    checkOutput("rxfull_busy", ifc.busy, 0);
    toDrive();
    ifc.rx_ready = 1'b1;
    toDrive();
    ifc.rx_ready = 1'b0;
    n = 0;
    while (startCount - base < 9 && n < 20) begin
      sampleEdge();
      n++;
    end
    checkOutput("rxfull_resume_starts", startCount - base, 9);
    toDrive();
    ifc.rx_ready = 1'b1;
    waitIdle("rxfull_drain", 100);
    n = 0;
    while (ifc.rx_valid !== 1'b0 && n < 20) begin
      sampleEdge();
      n++;
    end
    checkOutput("rxfull_rx_empty", ifc.rx_valid, 0);
`else
    waitIdle("norx_drain", 400);
    checkOutput("norx_starts", startCount - base, 9);
    checkOutput("norx_rx_valid", ifc.rx_valid, 0);
    checkOutput("norx_rx_data", ifc.rx_data, 8'h00);
    toDrive();
    ifc.rx_ready = 1'b1;
`endif

    // Reset asserted in WAIT_DONE abandons the transfer.
    toDrive();
    base = startCount;
    applyStimulus(8'h77, 1'b1, 8'h88, 1'b0);
    n = 0;
    while (!(ifc.drv_en === 1'b1 && ifc.busy === 1'b1) && n < 20) begin
      sampleEdge();
      n++;
    end
    if (ifc.drv_en !== 1'b1) failTimeout("rst_wait_done_wait");
    sampleEdge();
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) sampleEdge();
    checkOutput("midrst_starts", startCount - base, 1);
    checkOutput("midrst_busy_after", ifc.busy, 0);
    checkOutput("midrst_rx_valid_after", ifc.rx_valid, 0);
    toDrive();
    applyStimulus(8'h99, 1'b1, 8'h9A, 1'b1);
    waitIdle("recover_idle", 60);
    checkOutput("recover_starts", startCount - base, 2);
    repeat (3) sampleEdge();
    checkOutput("tx_queue_empty", txExp.size(), 0);
    checkOutput("rx_queue_empty", rxExp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
